// File: rtl/cd_pkg.sv
// Shared definitions for the cardinal mesh router input stage.
// Holds the header field positions, one-hot output port codes,
// the elastic buffer state encoding and a small hop-field helper.
package cd_pkg;

   // Header field positions, fixed for a 64-bit packet
   localparam int HDR_PKT_W = 64;
   localparam int VC_BIT    = 63;
   localparam int DX_BIT    = 62;
   localparam int DY_BIT    = 61;
   localparam int HX_LSB    = 52;
   localparam int HY_LSB    = 48;
   localparam int HOP_W     = 4;

   // One-hot output port requests {L,S,N,W,E}
   localparam logic [4:0] P_E = 5'b00001;
   localparam logic [4:0] P_W = 5'b00010;
   localparam logic [4:0] P_N = 5'b00100;
   localparam logic [4:0] P_S = 5'b01000;
   localparam logic [4:0] P_L = 5'b10000;

   // Two-entry elastic buffer occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   // Hop decrement; callers only use it on a non-zero field
   function automatic logic [HOP_W-1:0] hop_dec(input logic [HOP_W-1:0] hop);
      return hop - 4'd1;
   endfunction

endpackage

// File: rtl/cd_rc_fn.sv
// Combinational route compute and header rewrite.
// Dimension-ordered routing: X hops first, then Y, else local delivery.
// Only the consumed hop field is decremented; all other bits pass through.
// Ports:
//   pkt_in  - incoming 64-bit packet
//   pkt_out - packet with the used hop field decremented
//   port    - one-hot output request {L,S,N,W,E}
module cd_rc_fn
   import cd_pkg::*;
(
   input  logic [HDR_PKT_W-1:0] pkt_in,
   output logic [HDR_PKT_W-1:0] pkt_out,
   output logic [4:0]           port
);

   logic [HOP_W-1:0] hx_s;
   logic [HOP_W-1:0] hy_s;

   assign hx_s = pkt_in[HX_LSB +: HOP_W];
   assign hy_s = pkt_in[HY_LSB +: HOP_W];

   // Select direction and rewrite the hop field that was consumed
   always_comb begin
      pkt_out = pkt_in;
      port    = P_L;
      if (hx_s != 4'd0) begin
         pkt_out[HX_LSB +: HOP_W] = hop_dec(hx_s);
         if (pkt_in[DX_BIT]) begin
            port = P_W;
         end else begin
            port = P_E;
         end
      end else if (hy_s != 4'd0) begin
         pkt_out[HY_LSB +: HOP_W] = hop_dec(hy_s);
         if (pkt_in[DY_BIT]) begin
            port = P_S;
         end else begin
            port = P_N;
         end
      end else begin
         port = P_L;
      end
   end

endmodule

// File: rtl/cd_route_stage.sv
// Input-side route-compute stage of the cardinal mesh router.
// Routes each accepted packet, then holds it in a two-entry elastic
// buffer (main register feeding the outputs plus a skid register) so the
// stage runs at one packet per cycle with a registered in_ready.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake, in_pkt is the packet
//   out_valid/out_ready - allocator handshake
//   out_pkt/out_port    - rewritten packet and one-hot port request
//   out_vc              - virtual channel bit of out_pkt
//   pkt_cnt             - saturating count of packets handed downstream
module cd_route_stage
   import cd_pkg::*;
#(
   parameter int PKT_W = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PKT_W-1:0] in_pkt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PKT_W-1:0] out_pkt,
   output logic [4:0]       out_port,
   output logic             out_vc,
   output logic [CNT_W-1:0] pkt_cnt
);

   buf_state_e       state_r;
   buf_state_e       state_next_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [PKT_W-1:0] out_pkt_r;
   logic [4:0]       out_port_r;
   logic [PKT_W-1:0] skid_pkt_r;
   logic [4:0]       skid_port_r;
   logic [CNT_W-1:0] pkt_cnt_r;

   logic [PKT_W-1:0] rc_pkt_s;
   logic [4:0]       rc_port_s;
   logic             accept_s;
   logic             xfer_s;
   logic             load_m_in_s;
   logic             load_m_skid_s;
   logic             load_skid_s;

   cd_rc_fn u_rc (
      .pkt_in  (in_pkt),
      .pkt_out (rc_pkt_s),
      .port    (rc_port_s)
   );

   assign accept_s = in_valid & in_ready_r;
   assign xfer_s   = out_valid_r & out_ready;

   // Buffer next-state and register load selects
   always_comb begin
      state_next_s  = state_r;
      load_m_in_s   = 1'b0;
      load_m_skid_s = 1'b0;
      load_skid_s   = 1'b0;
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               load_m_in_s  = 1'b1;
               state_next_s = ONE;
            end else begin
               state_next_s = EMPTY;
            end
         end
         ONE: begin
            if (accept_s && xfer_s) begin
               load_m_in_s  = 1'b1;
               state_next_s = ONE;
            end else if (accept_s) begin
               load_skid_s  = 1'b1;
               state_next_s = FULL;
            end else if (xfer_s) begin
               state_next_s = EMPTY;
            end else begin
               state_next_s = ONE;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain path exists
            if (xfer_s) begin
               load_m_skid_s = 1'b1;
               state_next_s  = ONE;
            end else begin
               state_next_s = FULL;
            end
         end
         default: begin
            state_next_s = EMPTY;
         end
      endcase
   end

   // State register plus handshake flags decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s != FULL);
         out_valid_r <= (state_next_s != EMPTY);
      end
   end

   // Main and skid data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_pkt_r   <= {PKT_W{1'b0}};
         out_port_r  <= 5'b00000;
         skid_pkt_r  <= {PKT_W{1'b0}};
         skid_port_r <= 5'b00000;
      end else begin
         if (load_m_in_s) begin
            out_pkt_r  <= rc_pkt_s;
            out_port_r <= rc_port_s;
         end else if (load_m_skid_s) begin
            out_pkt_r  <= skid_pkt_r;
            out_port_r <= skid_port_r;
         end
         if (load_skid_s) begin
            skid_pkt_r  <= rc_pkt_s;
            skid_port_r <= rc_port_s;
         end
      end
   end

   // Saturating transfer counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt_r <= {CNT_W{1'b0}};
      end else if (xfer_s && (pkt_cnt_r != {CNT_W{1'b1}})) begin
         pkt_cnt_r <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_pkt   = out_pkt_r;
   assign out_port  = out_port_r;
   assign out_vc    = out_pkt_r[VC_BIT];
   assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_cd_route_stage.sv
// Self-checking bench for cd_route_stage: a queue-based reference model
// of the two-entry stage, checked on every falling edge, plus directed
// literal expectations for the routing examples, back-pressure, reset
// while full and counter saturation (second instance with CNT_W=4).
module tb_cd_route_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pkt;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pkt;
   logic [4:0]  out_port;
   logic        out_vc;
   logic [15:0] pkt_cnt;

   logic        in_ready4;
   logic        out_valid4;
   logic [63:0] out_pkt4;
   logic [4:0]  out_port4;
   logic        out_vc4;
   logic [3:0]  pkt_cnt4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pkt;
      logic [4:0]  port;
   } exp_t;

   exp_t q[$];
   int   n_xfer = 0;
   bit   m_acc;
   bit   m_xf;
   exp_t m_e;

   always #5 clk = ~clk;

   cd_route_stage #(.PKT_W(64), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pkt(in_pkt), .out_valid(out_valid), .out_ready(out_ready),
      .out_pkt(out_pkt), .out_port(out_port), .out_vc(out_vc), .pkt_cnt(pkt_cnt)
   );

   cd_route_stage #(.PKT_W(64), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_pkt(in_pkt), .out_valid(out_valid4), .out_ready(out_ready),
      .out_pkt(out_pkt4), .out_port(out_port4), .out_vc(out_vc4), .pkt_cnt(pkt_cnt4)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Routing rule: X hops first, then Y, else local; decrement the hop used
   function automatic void ref_route(input logic [63:0] p, output logic [63:0] o,
                                     output logic [4:0] port);
      int hx;
      int hy;
      hx = int'(p[55:52]);
      hy = int'(p[51:48]);
      o  = p;
      if (hx > 0) begin
         o[55:52] = 4'(hx - 1);
         port = p[62] ? 5'b00010 : 5'b00001;
      end else if (hy > 0) begin
         o[51:48] = 4'(hy - 1);
         port = p[61] ? 5'b01000 : 5'b00100;
      end else begin
         port = 5'b10000;
      end
   endfunction

   // Reference model: a FIFO of at most two routed packets
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         n_xfer = 0;
      end else begin
         m_acc = in_valid && (q.size() < 2);
         m_xf  = out_ready && (q.size() > 0);
         if (m_acc) ref_route(in_pkt, m_e.pkt, m_e.port);
         if (m_xf) begin
            void'(q.pop_front());
            n_xfer++;
         end
         if (m_acc) q.push_back(m_e);
      end
   end

   // Compare DUT outputs against the model away from the active edge
   always @(negedge clk) begin
      if (!reset) begin
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("pkt_cnt", 64'(pkt_cnt), 64'((n_xfer > 65535) ? 65535 : n_xfer));
         chk("pkt_cnt4", 64'(pkt_cnt4), 64'((n_xfer > 15) ? 15 : n_xfer));
         chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("out_pkt", out_pkt, q[0].pkt);
            chk("out_port", 64'(out_port), 64'(q[0].port));
            chk("out_vc", 64'(out_vc), 64'(q[0].pkt[63]));
            chk("onehot", 64'($onehot(out_port)), 64'd1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] PK_W  = 64'h4032_1234_DEAD_BEEF;
   localparam logic [63:0] PK_N  = 64'h8001_5678_0000_00AA;
   localparam logic [63:0] PK_L  = 64'h6000_0000_1111_2222;
   localparam logic [63:0] PK_S  = 64'h200F_0102_0304_0506;

   initial begin
      logic [63:0] r;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_pkt    = 64'd0;
      repeat (3) step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_pkt", out_pkt, 64'd0);
      chk("rst_out_port", 64'(out_port), 64'd0);
      chk("rst_out_vc", 64'(out_vc), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      reset = 1'b0;
      step();

      // Routing examples, one packet at a time
      out_ready = 1'b1;
      in_valid = 1'b1; in_pkt = PK_W; step(); in_valid = 1'b0;
      chk("t1_port", 64'(out_port), 64'(5'b00010));
      chk("t1_pkt", out_pkt, 64'h4022_1234_DEAD_BEEF);
      in_valid = 1'b1; in_pkt = PK_N; step(); in_valid = 1'b0;
      chk("t2_port", 64'(out_port), 64'(5'b00100));
      chk("t2_pkt", out_pkt, 64'h8000_5678_0000_00AA);
      chk("t2_vc", 64'(out_vc), 64'd1);
      in_valid = 1'b1; in_pkt = PK_L; step(); in_valid = 1'b0;
      chk("t2l_port", 64'(out_port), 64'(5'b10000));
      chk("t2l_pkt", out_pkt, PK_L);
      in_valid = 1'b1; in_pkt = PK_S; step(); in_valid = 1'b0;
      chk("ts_port", 64'(out_port), 64'(5'b01000));
      chk("ts_pkt", out_pkt, 64'h200E_0102_0304_0506);
      step();
      chk("t_idle", 64'(out_valid), 64'd0);

      // Back-pressure: A then B with out_ready low
      out_ready = 1'b0;
      in_valid = 1'b1; in_pkt = PK_W; step();
      in_pkt = PK_N; step(); in_valid = 1'b0;
      chk("t4_full_ready", 64'(in_ready), 64'd0);
      chk("t4_hold0", out_pkt, 64'h4022_1234_DEAD_BEEF);
      step(); step();
      chk("t4_hold1", out_pkt, 64'h4022_1234_DEAD_BEEF);
      chk("t4_hold_port", 64'(out_port), 64'(5'b00010));
      out_ready = 1'b1; step();
      chk("t4_b_pkt", out_pkt, 64'h8000_5678_0000_00AA);
      chk("t4_ready_back", 64'(in_ready), 64'd1);
      step();
      chk("t4_drained", 64'(out_valid), 64'd0);

      // Reset while full: contents dropped, outputs reset immediately
      out_ready = 1'b0;
      in_valid = 1'b1; in_pkt = PK_L; step();
      in_pkt = PK_S; step(); in_valid = 1'b0;
      chk("t5_full", 64'(in_ready), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("t5_out_pkt", out_pkt, 64'd0);
      #2 reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         step();
         chk("t5_no_ghost", 64'(out_valid), 64'd0);
      end

      // Eight back-to-back packets with the allocator always ready
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_pkt   = {$urandom, $urandom};
         step();
         chk("t3_in_ready", 64'(in_ready), 64'd1);
         chk("t3_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd8);

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         r = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) r[55:52] = 4'd0;
         if ($urandom_range(0, 2) == 0) r[51:48] = 4'd0;
         in_pkt = r;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("sat_pkt_cnt4", 64'(pkt_cnt4), 64'd15);
      chk("drain_idle", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
